// File: rtl/alu_arb2.sv
// Round-robin arbiter/sequencer for a shared external 4-bit ALU; grant->response 2 cycles, one op per 3 cycles, rsp_* held under rsp_ready backpressure.
// Optional per-requester saturating grant counters when ALU_ARB_STATS_EN is defined.
module alu_arb2 #(
  parameter int DATA_W     = 4,
  parameter int START_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ALU_ARB_STATS_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
`endif
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_sel,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_sel,
  output logic              req1_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic P_START = (START_PRIO != 0);

  if (DATA_W != 4 || CNT_W < 1) begin : g_bad_param
    $error("alu_arb2: DATA_W must be 4 and CNT_W at least 1");
  end

  state_t r_state;
  logic   r_ptr;
  logic   r_id;

  logic w_gnt0;
  logic w_gnt1;
  logic w_idle;
  logic w_hs0;
  logic w_hs1;

  // r_ptr names the requester that wins when both are valid.
  assign w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);
  assign w_gnt1 = req1_valid & (~req0_valid |  r_ptr);
  assign w_idle = (r_state == S_IDLE) & ~rst;

  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;
  assign w_hs0      = req0_valid & req0_ready;
  assign w_hs1      = req1_valid & req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= P_START;
      r_id       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs0) begin
            alu_a   <= req0_a;
            alu_b   <= req0_b;
            alu_sel <= req0_sel;
            r_id    <= 1'b0;
            r_ptr   <= 1'b1;
            r_state <= S_EXEC;
          end else if (w_hs1) begin
            alu_a   <= req1_a;
            alu_b   <= req1_b;
            alu_sel <= req1_sel;
            r_id    <= 1'b1;
            r_ptr   <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU operands have been stable for a full cycle; capture its result now.
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_id     <= r_id;
          rsp_valid  <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (w_hs0 && (grant_cnt0 != {CNT_W{1'b1}})) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (w_hs1 && (grant_cnt1 != {CNT_W{1'b1}})) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arb2.sv
// Self-checking bench for alu_arb2: vector table, reset/fairness sequences, randomized ops vs reference model.
module tb_alu_arb2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic [3:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] alu_sel;
  logic       alu_carry, rsp_valid, rsp_id, rsp_carry, rsp_ready;
`ifdef ALU_ARB_STATS_EN
  logic       cnt_clr;
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_ptr;

  always #5 clk = ~clk;

  alu_arb2 dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ALU_ARB_STATS_EN
    .cnt_clr    (cnt_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
`endif
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .req1_ready (req1_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ready  (rsp_ready)
  );

  // Behavioural ALU: {carry, result}.
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    case (sel)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, 4'(a - b)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      default: return 5'd0;
    endcase
  endfunction

  assign {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_carry"}, rsp_carry, 0);
    chk({tag, "_alu_abs"}, {alu_a, alu_b, alu_sel}, 0);
    chk({tag, "_readies"}, {req0_ready, req1_ready}, 0);
  endtask

  // One complete operation: grant, EXEC, RESP held for 'stall' extra cycles, then consumed.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] s0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] s1,
                        input int stall, input logic eid, input logic [3:0] eres, input logic ec);
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    rsp_ready  = (stall == 0);
    #1;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("grant_ready0", req0_ready, !eid);
    chk("grant_ready1", req1_ready, eid);
    @(negedge clk);
    if (eid) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_readies", {req0_ready, req1_ready}, 0);
    chk("alu_a", alu_a, eid ? a1 : a0);
    chk("alu_b", alu_b, eid ? b1 : b0);
    chk("alu_sel", alu_sel, eid ? s1 : s0);
    @(negedge clk);
    for (int j = 0; j <= stall; j++) begin
      if (j > 0) @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, eid);
      chk("rsp_result", rsp_result, eres);
      chk("rsp_carry", rsp_carry, ec);
      chk("resp_readies", {req0_ready, req1_ready}, 0);
      if (j == stall) rsp_ready = 1'b1;
    end
    m_ptr = ~eid;
  endtask

  // Reset while the op is in EXEC (when=1) or RESP (when=2); pointer was moved to 1 beforehand.
  task automatic reset_mid(input int when);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 4'h9; req0_b = 4'h8; req0_sel = 3'd0; rsp_ready = 1'b0;
    #1 chk("rst_pre_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    if (when == 2) @(negedge clk);
    chk("rst_pre_rsp_valid", rsp_valid, (when == 2));
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 rst = 1'b1;
    #1 chk_all_zero(when == 2 ? "rst_resp" : "rst_exec");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_after_ready0", req0_ready, 1);
    chk("rst_after_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_ptr = 1'b0;
  endtask

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    int         stall;
    logic [3:0] res;
    logic       c;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    int   k;
    tbl[0] = '{1'b0, 4'h9, 4'h8, 3'd0, 0, 4'h1, 1'b1};
    tbl[1] = '{1'b1, 4'hF, 4'hF, 3'd6, 0, 4'h0, 1'b0};
    tbl[2] = '{1'b1, 4'h2, 4'h5, 3'd1, 0, 4'hD, 1'b0};
    tbl[3] = '{1'b0, 4'hC, 4'hA, 3'd2, 5, 4'h8, 1'b0};
    tbl[4] = '{1'b1, 4'h3, 4'h0, 3'd5, 0, 4'hC, 1'b0};
    tbl[5] = '{1'b0, 4'h5, 4'h3, 3'd3, 2, 4'h7, 1'b0};
    tbl[6] = '{1'b1, 4'h6, 4'h3, 3'd4, 0, 4'h5, 1'b0};
    tbl[7] = '{1'b0, 4'h7, 4'h7, 3'd7, 0, 4'h0, 1'b0};
    tbl[8] = '{1'b1, 4'hF, 4'h1, 3'd0, 1, 4'h0, 1'b1};
    tbl[9] = '{1'b0, 4'h3, 4'h5, 3'd1, 0, 4'hE, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    cnt_clr = 1'b0;
`endif
    #12 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_ptr = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(!tbl[i].id, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sel,
             tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].stall, tbl[i].id, tbl[i].res, tbl[i].c);

    reset_mid(1);
    reset_mid(2);

    // Both requesters held valid: grants must alternate starting from requester 0.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'hA; req0_sel = 3'd2;
    req1_valid = 1'b1; req1_a = 4'h3; req1_b = 4'h0; req1_sel = 3'd5;
    rsp_ready  = 1'b1;
    #1 chk("fair_first_ready0", req0_ready, 1);
    k = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("fair_id", rsp_id, k % 2);
        chk("fair_result", rsp_result, (k % 2) ? 4'hC : 4'h8);
        k++;
      end
    end
    chk("fair_count", k, 6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    m_ptr = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int         v;
      logic [3:0] a0, b0, a1, b1;
      logic [2:0] s0, s1;
      logic       g;
      logic [4:0] r;
      v  = $urandom_range(1, 3);
      a0 = 4'($urandom); b0 = 4'($urandom); s0 = 3'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); s1 = 3'($urandom);
      g  = (v == 1) ? 1'b0 : (v == 2) ? 1'b1 : m_ptr;
      r  = g ? alu_ref(a1, b1, s1) : alu_ref(a0, b0, s0);
      run_op(v[0], v[1], a0, b0, s0, a1, b1, s1, $urandom_range(0, 3), g, r[3:0], r[4]);
    end

`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < 300; i++)
      run_op(1'b1, 1'b0, 4'h1, 4'h1, 3'd0, 4'h0, 4'h0, 3'd0, 0, 1'b0, 4'h2, 1'b0);
    @(negedge clk);
    chk("cnt0_saturated", grant_cnt0, 8'hFF);
    req0_valid = 1'b1; req1_valid = 1'b0; cnt_clr = 1'b1; rsp_ready = 1'b1;
    #1 chk("clr_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0; cnt_clr = 1'b0;
    chk("cnt0_clear_wins", grant_cnt0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    m_ptr = 1'b1;
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
